bcd_score_accumulator: RTL and testbench



---
 rtl/bcd_score_accumulator.sv | 119 +++++++++++
 tb/tb_bcd_score_accumulator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_score_accumulator.sv
// Multi-digit BCD score counter: adds per-event BCD points, saturates at all-nines,
// optionally counts only hit rising edges, and keeps a session high score.
module bcd_score_accumulator #(
  parameter int DIGITS     = 4,
  parameter int ADD_DIGITS = 2,
  parameter int EDGE_MODE  = 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    hit,
  input  logic [4*ADD_DIGITS-1:0] hit_pts,
  input  logic                    clear_score,
  input  logic                    game_over,
  output logic [4*DIGITS-1:0]     score,
  output logic [4*DIGITS-1:0]     hi_score,
  output logic                    sat,
  output logic                    bcd_err,
  output logic                    new_hi
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  // Event semantics: there is no handshake. An event (evt) is accepted in the
  // cycle it is seen, hit_pts is sampled in that same cycle, and the result is
  // visible on score after the next clk edge. One event per cycle is allowed.
  logic         hit_d;
  logic         evt;
  logic         pts_bad;
  logic         carry_out;
  logic         score_gt;
  logic [W-1:0] pts_ext;
  logic [W-1:0] sum;

  assign evt = (EDGE_MODE != 0) ? (hit & ~hit_d) : hit;

  always_comb begin
    pts_bad = 1'b0;
    pts_ext = '0;
    pts_ext[4*ADD_DIGITS-1:0] = hit_pts;
    for (int i = 0; i < ADD_DIGITS; i++) begin
      if (hit_pts[4*i +: 4] > 4'd9) pts_bad = 1'b1;
    end
  end

  // Ripple decimal add; the carry out of the top digit signals saturation.
  always_comb begin
    logic       carry;
    logic [4:0] dsum;
    logic [4:0] dfix;
    carry = 1'b0;
    dsum  = '0;
    dfix  = '0;
    sum   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dsum = {1'b0, score[4*i +: 4]} + {1'b0, pts_ext[4*i +: 4]} + {4'b0000, carry};
      dfix = dsum - 5'd10;
      if (dsum > 5'd9) begin
        sum[4*i +: 4] = dfix[3:0];
        carry         = 1'b1;
      end else begin
        sum[4*i +: 4] = dsum[3:0];
        carry         = 1'b0;
      end
    end
    carry_out = carry;
  end

  // Digit-wise magnitude compare from the most significant digit down.
  always_comb begin
    logic decided;
    decided  = 1'b0;
    score_gt = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!decided) begin
        if (score[4*i +: 4] > hi_score[4*i +: 4]) begin
          score_gt = 1'b1;
          decided  = 1'b1;
        end else if (score[4*i +: 4] < hi_score[4*i +: 4]) begin
          decided  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_d    <= 1'b0;
      score    <= '0;
      hi_score <= '0;
      sat      <= 1'b0;
      bcd_err  <= 1'b0;
      new_hi   <= 1'b0;
    end else begin
      hit_d   <= hit;
      bcd_err <= evt & pts_bad & ~clear_score;

      if (game_over && score_gt) begin
        hi_score <= score;
        new_hi   <= 1'b1;
      end else begin
        new_hi   <= 1'b0;
      end

      if (clear_score) begin
        score <= '0;
        sat   <= 1'b0;
      end else if (evt && !pts_bad) begin
        if (sat || carry_out) begin
          score <= ALL_NINES;
          sat   <= 1'b1;
        end else begin
          score <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_score_accumulator.sv
// Bench for bcd_score_accumulator: decimal integer model feeding an expected
// queue, plus fixed-value checks of the scoring scenarios.
module tb_bcd_score_accumulator;

  localparam int DIGITS = 4;
  localparam int ADD    = 2;
  localparam int W      = 8 * DIGITS + 3;

  logic        clk = 1'b0;
  logic        resetN;
  logic        hit;
  logic [7:0]  hit_pts;
  logic        clear_score;
  logic        game_over;
  logic [15:0] score, hi_score;
  logic        sat, bcd_err, new_hi;
  logic [15:0] lvl_score, lvl_hi;
  logic        lvl_sat, lvl_err, lvl_new_hi;

  int tests = 0;
  int fails = 0;

  int   m_score, m_hi;
  logic m_sat, m_hit_d;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  always #5 clk = ~clk;

  bcd_score_accumulator #(.DIGITS(DIGITS), .ADD_DIGITS(ADD), .EDGE_MODE(1)) dut (
    .clk(clk), .resetN(resetN), .hit(hit), .hit_pts(hit_pts),
    .clear_score(clear_score), .game_over(game_over),
    .score(score), .hi_score(hi_score), .sat(sat), .bcd_err(bcd_err), .new_hi(new_hi)
  );

  bcd_score_accumulator #(.DIGITS(DIGITS), .ADD_DIGITS(ADD), .EDGE_MODE(0)) dut_lvl (
    .clk(clk), .resetN(resetN), .hit(hit), .hit_pts(hit_pts),
    .clear_score(clear_score), .game_over(game_over),
    .score(lvl_score), .hi_score(lvl_hi), .sat(lvl_sat), .bcd_err(lvl_err), .new_hi(lvl_new_hi)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int pts_val(input logic [7:0] p);
    return int'(p[7:4]) * 10 + int'(p[3:0]);
  endfunction

  // Drive one cycle; tasks start and end at posedge+1.
  task automatic step(input logic h, input logic [7:0] p, input logic clr, input logic go);
    logic evt, bad, err, nh;
    int s;
    hit = h; hit_pts = p; clear_score = clr; game_over = go;
    evt = h & ~m_hit_d;
    m_hit_d = h;
    bad = (p[7:4] > 4'd9) || (p[3:0] > 4'd9);
    nh = 1'b0;
    err = 1'b0;
    if (go && m_score > m_hi) begin
      m_hi = m_score;
      nh = 1'b1;
    end
    if (clr) begin
      m_score = 0;
      m_sat = 1'b0;
    end else if (evt) begin
      if (bad) err = 1'b1;
      else begin
        s = m_score + pts_val(p);
        if (s > 9999) begin
          s = 9999;
          m_sat = 1'b1;
        end
        m_score = s;
      end
    end
    exp_q.push_back({to_bcd(m_score), to_bcd(m_hi), m_sat, err, nh});
    @(posedge clk);
    #1;
    obs_q.push_back({score, hi_score, sat, bcd_err, new_hi});
  endtask

  task automatic add(input logic [7:0] p);
    step(1'b1, p, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    hit = 1'b0; hit_pts = 8'h00; clear_score = 1'b0; game_over = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    m_score = 0; m_hi = 0; m_sat = 1'b0; m_hit_d = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] e, o;
    do_reset();
    add(8'h07);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL reset_seq: got %h expected %h", o, e); end
    end
    resetN = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({score, hi_score, sat, bcd_err, new_hi} !== '0) begin
      fails++; $display("FAIL reset_edge_dut: got %h expected 0", {score, hi_score, sat, bcd_err, new_hi});
    end
    tests++;
    if ({lvl_score, lvl_hi, lvl_sat, lvl_err, lvl_new_hi} !== '0) begin
      fails++; $display("FAIL reset_lvl_dut: got %h expected 0", {lvl_score, lvl_hi, lvl_sat, lvl_err, lvl_new_hi});
    end
    resetN = 1'b1;
  endtask

  task automatic test_edge_level();
    logic [W-1:0] e, o;
    do_reset();
    step(1'b1, 8'h01, 1'b0, 1'b0);
    tests++;
    if (score !== 16'h0001) begin fails++; $display("FAIL edge_first: score=%h expected 0001", score); end
    repeat (9) step(1'b1, 8'h01, 1'b0, 1'b0);
    tests++;
    if (score !== 16'h0001) begin fails++; $display("FAIL edge_held: score=%h expected 0001", score); end
    tests++;
    if ({lvl_score, lvl_hi, lvl_sat, lvl_err, lvl_new_hi} !== {16'h0010, 16'h0000, 3'b000}) begin
      fails++; $display("FAIL level_held: score=%h sat=%b expected 0010 sat 0", lvl_score, lvl_sat);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL edge_seq: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] e, o;
    do_reset();
    repeat (10) add(8'h99);
    add(8'h09);
    add(8'h01);
    tests++;
    if (score !== 16'h1000) begin fails++; $display("FAIL carry_1000: score=%h expected 1000", score); end
    add(8'h99);
    tests++;
    if ({score, sat} !== {16'h1099, 1'b0}) begin fails++; $display("FAIL carry_1099: score=%h sat=%b expected 1099 0", score, sat); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL carry_seq: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] e, o;
    do_reset();
    repeat (100) add(8'h99);
    add(8'h90);
    tests++;
    if (score !== 16'h9990) begin fails++; $display("FAIL sat_setup: score=%h expected 9990", score); end
    add(8'h20);
    tests++;
    if ({score, sat} !== {16'h9999, 1'b1}) begin fails++; $display("FAIL sat_hit: score=%h sat=%b expected 9999 1", score, sat); end
    add(8'h05);
    tests++;
    if ({score, sat} !== {16'h9999, 1'b1}) begin fails++; $display("FAIL sat_hold: score=%h sat=%b expected 9999 1", score, sat); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if ({score, sat} !== {16'h0000, 1'b0}) begin fails++; $display("FAIL sat_clear: score=%h sat=%b expected 0000 0", score, sat); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL sat_seq: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_invalid_bcd();
    logic [W-1:0] e, o;
    do_reset();
    add(8'h42);
    step(1'b1, 8'h1A, 1'b0, 1'b0);
    tests++;
    if ({score, bcd_err} !== {16'h0042, 1'b1}) begin fails++; $display("FAIL bcd_err_set: score=%h err=%b expected 0042 1", score, bcd_err); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    tests++;
    if (bcd_err !== 1'b0) begin fails++; $display("FAIL bcd_err_pulse: err=%b expected 0", bcd_err); end
    add(8'h10);
    tests++;
    if (score !== 16'h0052) begin fails++; $display("FAIL bcd_after: score=%h expected 0052", score); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL bcd_seq: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_high_score();
    logic [W-1:0] e, o;
    do_reset();
    add(8'h50);
    add(8'h50);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    add(8'h20);
    step(1'b1, 8'h05, 1'b0, 1'b1);
    tests++;
    if ({score, hi_score, new_hi} !== {16'h0125, 16'h0120, 1'b1}) begin
      fails++; $display("FAIL hi_commit: score=%h hi=%h new_hi=%b expected 0125 0120 1", score, hi_score, new_hi);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (new_hi !== 1'b0) begin fails++; $display("FAIL hi_pulse: new_hi=%b expected 0", new_hi); end
    add(8'h50);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    tests++;
    if ({hi_score, new_hi} !== {16'h0120, 1'b0}) begin
      fails++; $display("FAIL hi_lower: hi=%h new_hi=%b expected 0120 0", hi_score, new_hi);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL hi_seq: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e, o;
    do_reset();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL async_pre: got %h expected %h", o, e); end
    end
    hit = 1'b1; hit_pts = 8'h33;
    #3;
    resetN = 1'b0;
    #1;
    tests++;
    if ({score, hi_score, sat, bcd_err, new_hi} !== '0) begin
      fails++; $display("FAIL async_clear: got %h expected 0", {score, hi_score, sat, bcd_err, new_hi});
    end
    @(posedge clk);
    #1;
    hit = 1'b0;
    resetN = 1'b1;
    m_score = 0; m_hi = 0; m_sat = 1'b0; m_hit_d = 1'b0;
    step(1'b1, 8'h37, 1'b0, 1'b0);
    tests++;
    if (score !== 16'h0037) begin fails++; $display("FAIL async_first: score=%h expected 0037", score); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL async_post: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e, o;
    logic [7:0]   p;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      p[3:0] = 4'($urandom_range(0, 9));
      p[7:4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) p[3:0] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) p[7:4] = 4'($urandom_range(10, 15));
      step(1'($urandom_range(0, 1)), p, 1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 15) == 0));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL random_seq: got %h expected %h", o, e); end
    end
  endtask

  initial begin
    resetN = 1'b0;
    hit = 1'b0; hit_pts = 8'h00; clear_score = 1'b0; game_over = 1'b0;
    m_score = 0; m_hi = 0; m_sat = 1'b0; m_hit_d = 1'b0;
    test_reset();
    test_edge_level();
    test_carry();
    test_saturation();
    test_invalid_bcd();
    test_high_score();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
